// File: rtl/risc_acc_core.sv
// risc_acc_core: parametrised accumulator CPU with loadable instruction memory
//
// Programs are written byte-by-byte into imem while in LOAD. Raising run_en_i starts
// execution from PC 0, one 8-bit instruction per clock, until HLT or run_en_i drops.
//
// Ports:
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset (imem is not reset)
//   inst_we_i       imem write strobe, honoured in LOAD only
//   inst_address_i  imem write address; addresses >= IMEM_DEPTH are dropped
//   inst_data_i     instruction byte to write
//   run_en_i        1 = run from PC 0, 0 = return to LOAD
//   out_data_o      last value emitted by OUT
//   out_valid_o     one-cycle pulse when out_data_o updates
//   halted_o        high while halted
//   pc_o            current program counter
//
// Optional feature: define RISC_CARRY_EN to add a carry flag (ADD/SUB/SHL/SHR) and
// the JC instruction (opcode 111 with f=1).
module risc_acc_core #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 7,
    parameter int IMEM_DEPTH = 128,
    parameter int NREGS      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_we_i,
    input  logic [ADDR_W-1:0] inst_address_i,
    input  logic [7:0]        inst_data_i,
    input  logic              run_en_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              halted_o,
    output logic [ADDR_W-1:0] pc_o
);
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_e;

    state_e            state_q, state_d;
    logic [7:0]        imem_q [IMEM_DEPTH];
    logic [DATA_W-1:0] acc_q, acc_d, out_data_q, out_data_d, rval;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              out_valid_q, out_valid_d, halted_q, halted_d;
    logic [7:0]        instr;
    logic [2:0]        op;
    logic              f, r_ok, cy, cy_we;
    logic [1:0]        r;
`ifdef RISC_CARRY_EN
    logic              carry_q, carry_d;
`else
    logic              unused_cy;
    assign unused_cy = ^{cy, cy_we};
`endif

    assign instr  = (int'(pc_q) < IMEM_DEPTH) ? imem_q[pc_q] : 8'h00;
    assign op     = instr[7:5];
    assign f      = instr[4];
    assign r      = instr[1:0];
    // Registers at or above NREGS read as zero and ignore writes.
    assign r_ok   = int'(r) < NREGS;
    assign rval   = r_ok ? regs_q[r] : '0;
    assign pc_inc = (int'(pc_q) >= IMEM_DEPTH - 1) ? '0 : pc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && inst_we_i && int'(inst_address_i) < IMEM_DEPTH)
            imem_q[inst_address_i] <= inst_data_i;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        regs_d      = regs_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        cy          = 1'b0;
        cy_we       = 1'b0;
`ifdef RISC_CARRY_EN
        carry_d     = carry_q;
`endif
        // Dropping run_en_i pre-empts whatever instruction is current.
        if (state_q != S_LOAD && !run_en_i) begin
            state_d  = S_LOAD;
            pc_d     = '0;
            halted_d = 1'b0;
        end else if (state_q == S_LOAD && run_en_i) begin
            state_d = S_RUN;
            pc_d    = '0;
        end else if (state_q == S_RUN) begin
            pc_d = pc_inc;
            case (op)
                3'b000: acc_d = DATA_W'(instr[4:0]);
                3'b001: begin
                    {cy, acc_d} = f ? {1'b0, acc_q} - {1'b0, rval} : {1'b0, acc_q} + {1'b0, rval};
                    cy_we = 1'b1;
                end
                3'b010: acc_d = f ? acc_q ^ rval : acc_q & rval;
                3'b011: begin
                    if (f) acc_d = rval;
                    else if (r_ok) regs_d[r] = acc_q;
                end
                3'b100: begin
                    if (f) {acc_d, cy} = {1'b0, acc_q};
                    else {cy, acc_d} = {acc_q, 1'b0};
                    cy_we = 1'b1;
                end
                3'b101: pc_d = (acc_q != '0) ? ADDR_W'(instr[4:0]) : pc_inc;
                3'b110: begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                end
                3'b111: begin
`ifdef RISC_CARRY_EN
                    if (f) begin
                        pc_d = carry_q ? ADDR_W'(instr[3:0]) : pc_inc;
                    end else begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
`else
                    pc_d     = pc_q;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
`endif
                end
            endcase
`ifdef RISC_CARRY_EN
            if (cy_we) carry_d = cy;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            pc_q        <= '0;
            acc_q       <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
`ifdef RISC_CARRY_EN
            carry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            regs_q      <= regs_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
`ifdef RISC_CARRY_EN
            carry_q     <= carry_d;
`endif
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign halted_o    = halted_q;
    assign pc_o        = pc_q;
endmodule
